beta_scheduler: RTL and testbench

BETA_SCHEDULER -- requirements
Module: beta_scheduler

---
 rtl/beta_scheduler.sv | 160 ++++++++++++++++
 tb/tb_beta_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_scheduler.sv
// Beta annealing ramp scheduler: steps o_beta from beta_init to beta_max, one increment per dwell period.
// Optional HOLD phase at beta_max is enabled by defining BETA_SCHED_HOLD_EN; `BETA sets the beta width.

`ifndef BETA
`define BETA 16
`endif

// state | meaning
// IDLE  | waiting for start; o_beta and step_cnt keep the last run's values
// RAMP  | o_beta held for one dwell period, then incremented toward beta_max
// HOLD  | o_beta parked at beta_max for HOLD_CYCLES cycles (BETA_SCHED_HOLD_EN only)
// DONE  | single-cycle completion pulse, then back to IDLE
module beta_scheduler #(
  parameter int DWELL_W     = 16,
  parameter int STEP_W      = 12,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                      clk_mac,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic signed [`BETA-1:0]   beta_init,
  input  logic signed [`BETA-1:0]   beta_step,
  input  logic signed [`BETA-1:0]   beta_max,
  input  logic        [DWELL_W-1:0] dwell,
  output logic signed [`BETA-1:0]   o_beta,
  output logic                      busy,
  output logic                      done,
  output logic        [STEP_W-1:0]  step_cnt
);

  localparam int BW = `BETA;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic signed [BW-1:0] BETA_MIN     = {1'b1, {(BW-1){1'b0}}};
  localparam logic signed [BW:0]   BETA_MIN_EXT = {2'b11, {(BW-1){1'b0}}};

`ifdef BETA_SCHED_HOLD_EN
  localparam logic [1:0] ST_END = ST_HOLD;
`else
  localparam logic [1:0] ST_END = ST_DONE;
`endif

  logic [1:0]          state;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic [DWELL_W-1:0]  dwell_last;
  logic signed [BW:0]  sum_ext;
  logic signed [BW:0]  max_ext;
  logic                hit_max;
  logic                under_min;
  logic signed [BW-1:0] next_beta;
  logic                no_ramp;
  logic signed [BW-1:0] init_clamped;
  logic                hold_exit;

  // One extra bit keeps the sum exact so the clamp decision can never see a wrapped value.
  assign sum_ext   = {o_beta[BW-1], o_beta} + {beta_step[BW-1], beta_step};
  assign max_ext   = {beta_max[BW-1], beta_max};
  assign hit_max   = (sum_ext >= max_ext);
  assign under_min = (sum_ext < BETA_MIN_EXT);

  always_comb begin
    next_beta = sum_ext[BW-1:0];
    if (hit_max) begin
      next_beta = beta_max;
    end else if (under_min) begin
      next_beta = BETA_MIN;
    end
  end

  assign dwell_last   = (dwell == '0) ? '0 : dwell - 1'b1;
  assign no_ramp      = (beta_init >= beta_max) || beta_step[BW-1] || (beta_step == '0);
  assign init_clamped = (beta_init >= beta_max) ? beta_max : beta_init;

`ifdef BETA_SCHED_HOLD_EN
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? HC_W'(HOLD_CYCLES - 1) : '0;

  logic [HC_W-1:0] hold_cnt;

  // Reloaded whenever outside HOLD so it is always primed on entry.
  always_ff @(posedge clk_mac or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (state != ST_HOLD) begin
      hold_cnt <= HOLD_LOAD;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  assign hold_exit = (hold_cnt == '0);
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = (HOLD_CYCLES != 0);
  assign hold_exit       = 1'b1;
`endif

  always_ff @(posedge clk_mac or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      o_beta    <= '0;
      step_cnt  <= '0;
      dwell_cnt <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      dwell_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            step_cnt  <= '0;
            dwell_cnt <= '0;
            if (no_ramp) begin
              o_beta <= init_clamped;
              state  <= ST_END;
            end else begin
              o_beta <= beta_init;
              state  <= ST_RAMP;
            end
          end
        end
        ST_RAMP: begin
          // >= rather than == so a dwell shortened mid-run cannot strand the counter past its terminal count.
          if (dwell_cnt >= dwell_last) begin
            dwell_cnt <= '0;
            o_beta    <= next_beta;
            if (step_cnt != '1) begin
              step_cnt <= step_cnt + 1'b1;
            end
            if (hit_max) begin
              state <= ST_END;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_exit) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_RAMP) || (state == ST_HOLD);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_beta_scheduler.sv
// Self-checking bench for beta_scheduler: directed ramps, clamp/overflow corners, abort, reset, random runs.
// Expected traces come from a per-run model of the ramp rules; HOLD length follows BETA_SCHED_HOLD_EN.

`ifndef BETA
`define BETA 16
`endif

module tb_beta_scheduler;

  localparam int DWELL_W     = 16;
  localparam int STEP_W      = 12;
  localparam int HOLD_CYCLES = 4;
  localparam int BW          = `BETA;
  localparam int BMAX        = (1 << (BW - 1)) - 1;
`ifdef BETA_SCHED_HOLD_EN
  localparam int HOLD_EXP = HOLD_CYCLES;
`else
  localparam int HOLD_EXP = 0;
`endif

  logic                 clk_mac;
  logic                 reset_n;
  logic                 start;
  logic                 abort;
  logic signed [BW-1:0] beta_init;
  logic signed [BW-1:0] beta_step;
  logic signed [BW-1:0] beta_max;
  logic [DWELL_W-1:0]   dwell;
  logic signed [BW-1:0] o_beta;
  logic                 busy;
  logic                 done;
  logic [STEP_W-1:0]    step_cnt;

  beta_scheduler #(
    .DWELL_W    (DWELL_W),
    .STEP_W     (STEP_W),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk_mac  (clk_mac),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .beta_init(beta_init),
    .beta_step(beta_step),
    .beta_max (beta_max),
    .dwell    (dwell),
    .o_beta   (o_beta),
    .busy     (busy),
    .done     (done),
    .step_cnt (step_cnt)
  );

  initial clk_mac = 1'b0;
  always #5 clk_mac = ~clk_mac;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int beta;
    bit busy;
    bit done;
    int cnt;
  } exp_t;

  exp_t traj[$];

  // Expected per-cycle outputs from cycle 1 (after start) through the first IDLE cycle.
  function automatic void build_traj(int init, int step, int mx, int dw);
    int deff;
    int v;
    int cnt;
    traj.delete();
    deff = (dw == 0) ? 1 : dw;
    cnt  = 0;
    if (init >= mx || step <= 0) begin
      v = (init < mx) ? init : mx;
    end else begin
      v = init;
      while (v < mx) begin
        for (int i = 0; i < deff; i++) traj.push_back('{v, 1'b1, 1'b0, cnt});
        v   = (v + step >= mx) ? mx : v + step;
        cnt = cnt + 1;
      end
    end
    for (int i = 0; i < HOLD_EXP; i++) traj.push_back('{v, 1'b1, 1'b0, cnt});
    traj.push_back('{v, 1'b0, 1'b1, cnt});
    traj.push_back('{v, 1'b0, 1'b0, cnt});
  endfunction

  task automatic launch(int init, int step, int mx, int dw);
    @(posedge clk_mac); #1;
    beta_init = BW'(init);
    beta_step = BW'(step);
    beta_max  = BW'(mx);
    dwell     = DWELL_W'(dw);
    start     = 1'b1;
    build_traj(init, step, mx, dw);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0;
    beta_init = '0; beta_step = '0; beta_max = '0; dwell = '0;
    #12;
    n_checks++;
    if (o_beta !== '0 || busy !== 1'b0 || done !== 1'b0 || step_cnt !== '0)
      $display("FAIL reset: o_beta=%0d busy=%b done=%b step_cnt=%0d, want 0 0 0 0", o_beta, busy, done, step_cnt);
    else n_pass++;
    @(negedge clk_mac);
    reset_n = 1'b1;
  endtask

  // Spec example ramp, clamp case and overflow corner, each walked cycle by cycle.
  task automatic test_ramp_table;
    int tbl[4][4];
    tbl[0] = '{0, 4, 16, 3};
    tbl[1] = '{0, 5, 16, 1};
    tbl[2] = '{BMAX - 1, BMAX, BMAX, 1};
    tbl[3] = '{-7, 3, 5, 0};
    for (int t = 0; t < 4; t++) begin
      launch(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3]);
      foreach (traj[k]) begin
        @(posedge clk_mac); #1;
        start = 1'b0;
        n_checks++;
        if (int'(o_beta) !== traj[k].beta || busy !== traj[k].busy || done !== traj[k].done ||
            int'(step_cnt) !== traj[k].cnt)
          $display("FAIL ramp_table[%0d] cyc%0d: o_beta=%0d busy=%b done=%b step_cnt=%0d, want %0d %b %b %0d",
                   t, k + 1, o_beta, busy, done, step_cnt, traj[k].beta, traj[k].busy, traj[k].done, traj[k].cnt);
        else n_pass++;
      end
    end
  endtask

  task automatic test_early_exit;
    int tbl[3][4];
    tbl[0] = '{20, 4, 16, 2};
    tbl[1] = '{3, 0, 16, 2};
    tbl[2] = '{-5, -2, 10, 1};
    for (int t = 0; t < 3; t++) begin
      launch(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3]);
      foreach (traj[k]) begin
        @(posedge clk_mac); #1;
        start = 1'b0;
        n_checks++;
        if (int'(o_beta) !== traj[k].beta || busy !== traj[k].busy || done !== traj[k].done ||
            int'(step_cnt) !== traj[k].cnt)
          $display("FAIL early_exit[%0d] cyc%0d: o_beta=%0d busy=%b done=%b step_cnt=%0d, want %0d %b %b %0d",
                   t, k + 1, o_beta, busy, done, step_cnt, traj[k].beta, traj[k].busy, traj[k].done, traj[k].cnt);
        else n_pass++;
      end
    end
  endtask

  task automatic test_abort;
    launch(0, 4, 16, 3);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk_mac); #1;
      start = 1'b0;
    end
    n_checks++;
    if (o_beta !== 16'sd4 || busy !== 1'b1)
      $display("FAIL abort_pre: o_beta=%0d busy=%b, want 4 1", o_beta, busy);
    else n_pass++;
    abort = 1'b1;
    @(posedge clk_mac); #1;
    abort = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (o_beta !== 16'sd4 || busy !== 1'b0 || done !== 1'b0 || step_cnt !== 12'd1)
        $display("FAIL abort_idle cyc%0d: o_beta=%0d busy=%b done=%b step_cnt=%0d, want 4 0 0 1",
                 6 + c, o_beta, busy, done, step_cnt);
      else n_pass++;
      @(posedge clk_mac); #1;
    end
    start = 1'b1; abort = 1'b1;
    @(posedge clk_mac); #1;
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || o_beta !== 16'sd4)
        $display("FAIL abort_with_start cyc%0d: busy=%b done=%b o_beta=%0d, want 0 0 4", c, busy, done, o_beta);
      else n_pass++;
      @(posedge clk_mac); #1;
    end
  endtask

  task automatic test_reset_mid_run;
    launch(0, 4, 16, 3);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk_mac); #1;
      start = 1'b0;
    end
    @(negedge clk_mac);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (o_beta !== '0 || busy !== 1'b0 || done !== 1'b0 || step_cnt !== '0)
      $display("FAIL reset_mid_run: o_beta=%0d busy=%b done=%b step_cnt=%0d, want 0 0 0 0", o_beta, busy, done, step_cnt);
    else n_pass++;
    #2;
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_mac); #1;
      n_checks++;
      if (busy !== 1'b0 || o_beta !== '0)
        $display("FAIL reset_wait_idle cyc%0d: busy=%b o_beta=%0d, want 0 0", c, busy, o_beta);
      else n_pass++;
    end
    launch(0, 4, 16, 3);
    foreach (traj[k]) begin
      @(posedge clk_mac); #1;
      start = 1'b0;
      n_checks++;
      if (int'(o_beta) !== traj[k].beta || busy !== traj[k].busy || done !== traj[k].done ||
          int'(step_cnt) !== traj[k].cnt)
        $display("FAIL reset_rerun cyc%0d: o_beta=%0d busy=%b done=%b step_cnt=%0d, want %0d %b %b %0d",
                 k + 1, o_beta, busy, done, step_cnt, traj[k].beta, traj[k].busy, traj[k].done, traj[k].cnt);
      else n_pass++;
    end
  endtask

  // Random ramps; start is toggled randomly while busy to confirm it is ignored.
  task automatic test_random_back_to_back;
    int init, step, mx, dw;
    for (int r = 0; r < 25; r++) begin
      init = int'($urandom_range(0, 400)) - 200;
      dw   = int'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) begin
        step = -int'($urandom_range(0, 5));
        mx   = init + int'($urandom_range(0, 60));
      end else begin
        step = int'($urandom_range(1, 50));
        mx   = init + int'($urandom_range(0, 150)) - (($urandom_range(0, 9) == 0) ? 80 : 0);
      end
      launch(init, step, mx, dw);
      foreach (traj[k]) begin
        @(posedge clk_mac); #1;
        start = (k < traj.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        n_checks++;
        if (int'(o_beta) !== traj[k].beta || busy !== traj[k].busy || done !== traj[k].done ||
            int'(step_cnt) !== traj[k].cnt)
          $display("FAIL random[%0d] init=%0d step=%0d max=%0d dwell=%0d cyc%0d: o_beta=%0d busy=%b done=%b step_cnt=%0d, want %0d %b %b %0d",
                   r, init, step, mx, dw, k + 1, o_beta, busy, done, step_cnt,
                   traj[k].beta, traj[k].busy, traj[k].done, traj[k].cnt);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_ramp_table;
    test_early_exit;
    test_abort;
    test_reset_mid_run;
    test_random_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
